sh7604_divu_arb: RTL and testbench

- Shares the SH7604 on-chip divider register window (FFFFFF00h–FFFFFF1Fh) between two internal-bus masters: M0 = CPU core, M1 = DMAC.
- Sits between those two internal-bus ports and the divider's single slave port.
- Arbitrates each access and holds an ownership lock from a division-start write until the owner reads the result, so one master cannot corrupt another's division.

---
 rtl/sh7604_divu_arb_pkg.sv | 48 ++++
 rtl/sh7604_divu_arb_lock.sv | 64 ++++++
 rtl/sh7604_divu_arb.sv | 160 ++++++++++++++++
 tb/tb_sh7604_divu_arb.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sh7604_divu_arb_pkg.sv
// Shared types and constants for the SH7604 divider-window arbiter.
// Optional build macro used by the top: SH7604_DIVARB_RR_EN (round-robin tie-break).
package sh7604_divu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } divarb_state_t;

    // Divider register window on the internal bus
    localparam logic [31:0] DIVU_BASE  = 32'hFFFF_FF00;
    localparam logic [31:0] DIVU_LIMIT = 32'hFFFF_FF1F;

    // Writes here start a division; reads here return a result
    localparam logic [4:0] OFS_START_A = 5'h04;
    localparam logic [4:0] OFS_START_B = 5'h14;
    localparam logic [4:0] OFS_RES_A   = 5'h04;
    localparam logic [4:0] OFS_RES_B   = 5'h14;
    localparam logic [4:0] OFS_RES_C   = 5'h1C;

    // Lock owner codes as seen on LOCK_OWN
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= DIVU_BASE) && (a <= DIVU_LIMIT);
    endfunction

    function automatic logic is_start_ofs(input logic [4:0] ofs);
        return (ofs == OFS_START_A) || (ofs == OFS_START_B);
    endfunction

    function automatic logic is_result_ofs(input logic [4:0] ofs);
        return (ofs == OFS_RES_A) || (ofs == OFS_RES_B) || (ofs == OFS_RES_C);
    endfunction

    // Owner code of the master a grant state serves (OWN_NONE when idle)
    function automatic logic [1:0] grant_code(input divarb_state_t s);
        case (s)
            ST_G0:   return OWN_M0;
            ST_G1:   return OWN_M1;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sh7604_divu_arb_lock.sv
// Division ownership lock: owner register, abandonment timer and the
// one-tick timeout pulse. All updates happen on the CE_R tick only.
module sh7604_divarb_lock #(
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ce_i,
    input  logic       set_i,      // start write forwarded this tick
    input  logic [1:0] set_own_i,  // owner code of the master that wrote
    input  logic       release_i,  // owner's result read forwarded this tick
    input  logic       hold_i,     // owner is granted, or is being granted this tick
    output logic [1:0] own_o,
    output logic       to_o
);

    localparam logic [7:0] TO_LAST = 8'(LOCK_TIMEOUT - 1);

    logic [1:0] own_q, own_d;
    logic [7:0] timer_q, timer_d;
    logic       to_q, to_d;

    // Next lock state: set beats release beats timeout; an owner grant keeps the timer at zero
    always_comb begin
        own_d   = own_q;
        timer_d = timer_q;
        to_d    = to_q;
        if (ce_i) begin
            to_d = 1'b0;
            if (set_i) begin
                own_d   = set_own_i;
                timer_d = 8'd0;
            end else if (release_i) begin
                own_d   = 2'b00;
                timer_d = 8'd0;
            end else if ((own_q == 2'b00) || hold_i) begin
                timer_d = 8'd0;
            end else if (timer_q == TO_LAST) begin
                own_d   = 2'b00;
                timer_d = 8'd0;
                to_d    = 1'b1;
            end else begin
                timer_d = timer_q + 8'd1;
            end
        end
    end

    // Lock registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            own_q   <= 2'b00;
            timer_q <= 8'd0;
            to_q    <= 1'b0;
        end else begin
            own_q   <= own_d;
            timer_q <= timer_d;
            to_q    <= to_d;
        end
    end

    assign own_o = own_q;
    assign to_o  = to_q;

endmodule

// File: rtl/sh7604_divu_arb.sv
// Two-master arbiter for the SH7604 divider register window (M0 = CPU, M1 = DMAC).
// Build macro: SH7604_DIVARB_RR_EN selects round-robin tie-break; otherwise FIXED_PRIO wins.
//
// Bus handshake: a master presents REQ with A/DI/BA/WE and holds them while BUSY=1;
// the access completes on a CE_R tick where REQ=1 and BUSY=0, with read data on DO.
// A granted master's access is forwarded as D_REQ and completes when D_BUSY=0.
module sh7604_divu_arb
    import sh7604_divu_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 64,
    parameter int FIXED_PRIO   = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic [31:0] M0_A,
    input  logic [31:0] M1_A,
    input  logic [31:0] M0_DI,
    input  logic [31:0] M1_DI,
    input  logic [3:0]  M0_BA,
    input  logic [3:0]  M1_BA,
    input  logic        M0_WE,
    input  logic        M1_WE,
    input  logic        M0_REQ,
    input  logic        M1_REQ,
    output logic [31:0] M0_DO,
    output logic [31:0] M1_DO,
    output logic        M0_BUSY,
    output logic        M1_BUSY,
    output logic [31:0] D_A,
    output logic [31:0] D_DI,
    output logic [3:0]  D_BA,
    output logic        D_WE,
    output logic        D_REQ,
    input  logic [31:0] D_DO,
    input  logic        D_BUSY,
    output logic [1:0]  LOCK_OWN,
    output logic        LOCK_TO
);

    divarb_state_t state_q, state_d;
    logic          sel0, sel1;
    logic          elig0, elig1;
    logic          tie_m1;
    logic [1:0]    lock_own;
    logic [1:0]    cur_code;
    logic          lock_set, lock_rel, lock_hold;

    assign sel0 = M0_REQ && in_window(M0_A);
    assign sel1 = M1_REQ && in_window(M1_A);

    // A master may be granted only while the lock is free or its own
    assign elig0 = sel0 && (lock_own != OWN_M1);
    assign elig1 = sel1 && (lock_own != OWN_M0);

`ifdef SH7604_DIVARB_RR_EN
    logic last_m1_q;

    // Remember who was granted last; starts at M1 so M0 wins the first tie
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            last_m1_q <= 1'b1;
        end else if (CE_R && (state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
            last_m1_q <= (state_d == ST_G1);
        end
    end

    assign tie_m1 = !last_m1_q;
`else
    localparam logic TIE_M1 = (FIXED_PRIO != 0);
    assign tie_m1 = TIE_M1;
`endif

    // FSM state register, advanced only on CE_R
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else if (CE_R) begin
            state_q <= state_d;
        end
    end

    // FSM next state: grant from IDLE, return to IDLE when the owner deselects
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (elig0 && elig1) begin
                    state_d = tie_m1 ? ST_G1 : ST_G0;
                end else if (elig0) begin
                    state_d = ST_G0;
                end else if (elig1) begin
                    state_d = ST_G1;
                end
            end
            ST_G0:   if (!sel0) state_d = ST_IDLE;
            ST_G1:   if (!sel1) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: forward the granted master, stall every other selected master.
    // Only in-window accesses are forwarded, and everything reads zero while in reset.
    always_comb begin
        D_A     = 32'd0;
        D_DI    = 32'd0;
        D_BA    = 4'd0;
        D_WE    = 1'b0;
        D_REQ   = 1'b0;
        M0_BUSY = 1'b0;
        M1_BUSY = 1'b0;
        M0_DO   = 32'd0;
        M1_DO   = 32'd0;
        if (RST_N) begin
            M0_BUSY = sel0;
            M1_BUSY = sel1;
            if ((state_q == ST_G0) && sel0) begin
                D_A     = M0_A;
                D_DI    = M0_DI;
                D_BA    = M0_BA;
                D_WE    = M0_WE;
                D_REQ   = 1'b1;
                M0_BUSY = D_BUSY;
                M0_DO   = D_DO;
            end else if ((state_q == ST_G1) && sel1) begin
                D_A     = M1_A;
                D_DI    = M1_DI;
                D_BA    = M1_BA;
                D_WE    = M1_WE;
                D_REQ   = 1'b1;
                M1_BUSY = D_BUSY;
                M1_DO   = D_DO;
            end
        end
    end

    // Lock strobes are decoded from the forwarded access itself
    assign cur_code  = grant_code(state_q);
    assign lock_set  = D_REQ && D_WE && !D_BUSY && is_start_ofs(D_A[4:0]);
    assign lock_rel  = D_REQ && !D_WE && !D_BUSY && is_result_ofs(D_A[4:0])
                       && (lock_own == cur_code);
    assign lock_hold = (lock_own == cur_code) || (lock_own == grant_code(state_d));

    sh7604_divarb_lock #(
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) u_lock (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .ce_i     (CE_R),
        .set_i    (lock_set),
        .set_own_i(cur_code),
        .release_i(lock_rel),
        .hold_i   (lock_hold),
        .own_o    (lock_own),
        .to_o     (LOCK_TO)
    );

    assign LOCK_OWN = lock_own;

endmodule

// File: tb/tb_sh7604_divu_arb.sv
// Self-checking bench for sh7604_divu_arb (LOCK_TIMEOUT=8, FIXED_PRIO=0).
// Honors SH7604_DIVARB_RR_EN for the tie-break expectations.
module tb_sh7604_divu_arb;

    localparam int TO = 8;

    logic        CLK = 1'b0;
    logic        RST_N, CE_R;
    logic [31:0] M0_A, M1_A, M0_DI, M1_DI, M0_DO, M1_DO;
    logic [3:0]  M0_BA, M1_BA;
    logic        M0_WE, M1_WE, M0_REQ, M1_REQ, M0_BUSY, M1_BUSY;
    logic [31:0] D_A, D_DI, D_DO;
    logic [3:0]  D_BA;
    logic        D_WE, D_REQ, D_BUSY;
    logic [1:0]  LOCK_OWN;
    logic        LOCK_TO;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who holds the port (0 none, 1 M0, 2 M1), lock owner, idle-tick count
    int m_g, m_own, m_timer, m_to, m_last;
    logic [31:0] e_da, e_ddi, e_m0do, e_m1do;
    logic [3:0]  e_dba;
    logic        e_dwe, e_dreq, e_m0b, e_m1b;

    always #5 CLK = ~CLK;

    sh7604_divu_arb #(.LOCK_TIMEOUT(TO), .FIXED_PRIO(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R),
        .M0_A(M0_A), .M1_A(M1_A), .M0_DI(M0_DI), .M1_DI(M1_DI),
        .M0_BA(M0_BA), .M1_BA(M1_BA), .M0_WE(M0_WE), .M1_WE(M1_WE),
        .M0_REQ(M0_REQ), .M1_REQ(M1_REQ), .M0_DO(M0_DO), .M1_DO(M1_DO),
        .M0_BUSY(M0_BUSY), .M1_BUSY(M1_BUSY),
        .D_A(D_A), .D_DI(D_DI), .D_BA(D_BA), .D_WE(D_WE), .D_REQ(D_REQ),
        .D_DO(D_DO), .D_BUSY(D_BUSY), .LOCK_OWN(LOCK_OWN), .LOCK_TO(LOCK_TO)
    );

    function automatic bit win(input logic [31:0] a);
        return (a >= 32'hFFFF_FF00) && (a <= 32'hFFFF_FF1F);
    endfunction

    task automatic model_reset();
        m_g = 0; m_own = 0; m_timer = 0; m_to = 0; m_last = 2;
    endtask

    // Expected combinational outputs for the current inputs
    task automatic model_comb();
        bit s0, s1;
        s0 = M0_REQ && win(M0_A);
        s1 = M1_REQ && win(M1_A);
        e_da = 0; e_ddi = 0; e_dba = 0; e_dwe = 0; e_dreq = 0;
        e_m0do = 0; e_m1do = 0; e_m0b = s0; e_m1b = s1;
        if (m_g == 1 && s0) begin
            e_dreq = 1; e_da = M0_A; e_ddi = M0_DI; e_dba = M0_BA; e_dwe = M0_WE;
            e_m0b = D_BUSY; e_m0do = D_DO;
        end
        if (m_g == 2 && s1) begin
            e_dreq = 1; e_da = M1_A; e_ddi = M1_DI; e_dba = M1_BA; e_dwe = M1_WE;
            e_m1b = D_BUSY; e_m1do = D_DO;
        end
    endtask

    // Advance the model by one CE_R tick
    task automatic model_step();
        bit s0, s1, fwd, wr, set_ev, rel_ev, e0, e1;
        logic [4:0] off;
        int gn;
        s0 = M0_REQ && win(M0_A);
        s1 = M1_REQ && win(M1_A);
        fwd = (m_g == 1 && s0) || (m_g == 2 && s1);
        off = (m_g == 2) ? M1_A[4:0] : M0_A[4:0];
        wr  = (m_g == 2) ? M1_WE : M0_WE;
        set_ev = fwd && wr && !D_BUSY && (off inside {5'h04, 5'h14});
        rel_ev = fwd && !wr && !D_BUSY && (off inside {5'h04, 5'h14, 5'h1C}) && (m_own == m_g);
        if (m_g == 1) gn = s0 ? 1 : 0;
        else if (m_g == 2) gn = s1 ? 2 : 0;
        else begin
            e0 = s0 && (m_own != 2);
            e1 = s1 && (m_own != 1);
            if (e0 && e1) begin
`ifdef SH7604_DIVARB_RR_EN
                gn = (m_last == 2) ? 1 : 2;
`else
                gn = 1;
`endif
            end else if (e0) gn = 1;
            else if (e1) gn = 2;
            else gn = 0;
        end
        m_to = 0;
        if (set_ev) begin
            m_own = m_g; m_timer = 0;
        end else if (rel_ev) begin
            m_own = 0; m_timer = 0;
        end else if (m_own != 0) begin
            if (m_own == m_g || m_own == gn) m_timer = 0;
            else begin
                m_timer++;
                if (m_timer == TO) begin
                    m_own = 0; m_timer = 0; m_to = 1;
                end
            end
        end
        if (m_g == 0 && gn != 0) m_last = gn;
        m_g = gn;
    endtask

    // One CE_R tick = two CLK cycles, CE_R high for the first; ends at a negedge
    task automatic tick();
        CE_R = 1'b1;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        CE_R = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic apply();
        #1;
        model_comb();
    endtask

    task automatic set_m(input int m, input bit req, input logic [31:0] a,
                         input bit we, input logic [31:0] di);
        if (m == 0) begin
            M0_REQ = req; M0_A = a; M0_WE = we; M0_DI = di; M0_BA = 4'hF;
        end else begin
            M1_REQ = req; M1_A = a; M1_WE = we; M1_DI = di; M1_BA = 4'hF;
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        CE_R  = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        set_m(0, 1, 32'hFFFF_FF04, 1, 32'h55);
        set_m(1, 1, 32'hFFFF_FF08, 0, 32'h0);
        D_BUSY = 1'b1; D_DO = 32'hCAFE_0001;
        RST_N = 1'b0; CE_R = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++; if (D_REQ !== 1'b0) $display("FAIL reset_d_req: got %b want 0", D_REQ); else n_pass++;
        n_checks++; if ({D_A, D_DI, D_BA, D_WE} !== 69'd0) $display("FAIL reset_d_bus: got %h want 0", {D_A, D_DI, D_BA, D_WE}); else n_pass++;
        n_checks++; if ({M0_BUSY, M1_BUSY} !== 2'b00) $display("FAIL reset_busy: got %b want 00", {M0_BUSY, M1_BUSY}); else n_pass++;
        n_checks++; if ({M0_DO, M1_DO} !== 64'd0) $display("FAIL reset_do: got %h want 0", {M0_DO, M1_DO}); else n_pass++;
        n_checks++; if ({LOCK_OWN, LOCK_TO} !== 3'b000) $display("FAIL reset_lock: got %b want 000", {LOCK_OWN, LOCK_TO}); else n_pass++;
        set_m(1, 0, 32'h0, 0, 32'h0);
        RST_N = 1'b1;
        model_reset();
        apply();
        n_checks++; if ({M0_BUSY, D_REQ} !== 2'b10) $display("FAIL reset_release_idle: got busy/dreq %b want 10", {M0_BUSY, D_REQ}); else n_pass++;
        set_m(0, 0, 32'h0, 0, 32'h0);
        apply();
    endtask

    task automatic test_lock_basic();
        do_reset();
        D_BUSY = 1'b0; D_DO = 32'h1234_5678;
        set_m(0, 1, 32'hFFFF_FF04, 1, 32'd100);
        apply();
        tick();
        n_checks++;
        if ({D_REQ, D_A, D_DI, D_WE, M0_BUSY, M0_DO} !== {1'b1, 32'hFFFF_FF04, 32'd100, 1'b1, 1'b0, 32'h1234_5678})
            $display("FAIL basic_grant: got req=%b a=%h di=%0d we=%b busy=%b do=%h", D_REQ, D_A, D_DI, D_WE, M0_BUSY, M0_DO);
        else n_pass++;
        tick();
        n_checks++; if (LOCK_OWN !== 2'b01) $display("FAIL basic_lock_set: got %b want 01", LOCK_OWN); else n_pass++;
        set_m(0, 1, 32'hFFFF_FF1C, 0, 32'd0);
        apply();
        tick();
        n_checks++; if (LOCK_OWN !== 2'b00) $display("FAIL basic_lock_release: got %b want 00", LOCK_OWN); else n_pass++;
        set_m(0, 0, 32'h0, 0, 32'h0);
        apply();
        tick();
    endtask

    task automatic test_prio();
        do_reset();
        D_BUSY = 1'b0; D_DO = 32'h0BAD_F00D;
        set_m(0, 1, 32'hFFFF_FF00, 0, 32'h0);
        set_m(1, 1, 32'hFFFF_FF08, 0, 32'h0);
        apply();
        n_checks++; if ({M0_BUSY, M1_BUSY} !== 2'b11) $display("FAIL prio_idle_busy: got %b want 11", {M0_BUSY, M1_BUSY}); else n_pass++;
        tick();
        n_checks++; if ({D_A, M0_BUSY, M1_BUSY} !== {32'hFFFF_FF00, 2'b01}) $display("FAIL prio_m0_wins: got a=%h busy=%b%b", D_A, M0_BUSY, M1_BUSY); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({M1_BUSY, M1_DO} !== {1'b1, 32'd0}) $display("FAIL prio_m1_stall: got busy=%b do=%h", M1_BUSY, M1_DO); else n_pass++;
        end
        set_m(0, 0, 32'h0, 0, 32'h0);
        apply();
        tick();
        n_checks++; if ({M1_BUSY, D_REQ} !== 2'b10) $display("FAIL prio_idle_gap: got busy/dreq %b want 10", {M1_BUSY, D_REQ}); else n_pass++;
        tick();
        n_checks++; if ({D_A, M1_BUSY, M1_DO} !== {32'hFFFF_FF08, 1'b0, 32'h0BAD_F00D}) $display("FAIL prio_m1_grant: got a=%h busy=%b do=%h", D_A, M1_BUSY, M1_DO); else n_pass++;
        set_m(1, 0, 32'h0, 0, 32'h0);
        apply();
        tick();
    endtask

    task automatic test_lock_block();
        do_reset();
        D_BUSY = 1'b0; D_DO = 32'h7;
        set_m(1, 1, 32'hFFFF_FF14, 1, 32'd7);
        apply();
        tick();
        tick();
        n_checks++; if (LOCK_OWN !== 2'b10) $display("FAIL block_lock_m1: got %b want 10", LOCK_OWN); else n_pass++;
        set_m(0, 1, 32'hFFFF_FF00, 0, 32'h0);
        set_m(1, 1, 32'hFFFF_FF10, 0, 32'h0);
        apply();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if ({M0_BUSY, D_A} !== {1'b1, 32'hFFFF_FF10}) $display("FAIL block_hold: got busy=%b a=%h", M0_BUSY, D_A); else n_pass++;
        end
        set_m(1, 0, 32'h0, 0, 32'h0);
        apply();
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({M0_BUSY, D_REQ, LOCK_OWN} !== {1'b1, 1'b0, 2'b10})
                $display("FAIL block_idle: got busy=%b dreq=%b own=%b", M0_BUSY, D_REQ, LOCK_OWN);
            else n_pass++;
        end
        set_m(1, 1, 32'hFFFF_FF14, 0, 32'h0);
        apply();
        tick();
        n_checks++; if ({D_A, M0_BUSY} !== {32'hFFFF_FF14, 1'b1}) $display("FAIL block_owner_back: got a=%h busy=%b", D_A, M0_BUSY); else n_pass++;
        tick();
        n_checks++; if (LOCK_OWN !== 2'b00) $display("FAIL block_release: got %b want 00", LOCK_OWN); else n_pass++;
        set_m(1, 0, 32'h0, 0, 32'h0);
        apply();
        tick();
        n_checks++; if (M0_BUSY !== 1'b1) $display("FAIL block_gap: got %b want 1", M0_BUSY); else n_pass++;
        tick();
        n_checks++; if ({D_A, M0_BUSY} !== {32'hFFFF_FF00, 1'b0}) $display("FAIL block_m0_grant: got a=%h busy=%b", D_A, M0_BUSY); else n_pass++;
        set_m(0, 0, 32'h0, 0, 32'h0);
        apply();
        tick();
    endtask

    task automatic test_timeout();
        int pulses;
        do_reset();
        D_BUSY = 1'b0; D_DO = 32'h0;
        set_m(0, 1, 32'hFFFF_FF04, 1, 32'd100);
        apply();
        tick();
        tick();
        set_m(0, 0, 32'h0, 0, 32'h0);
        apply();
        tick();
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k < TO) begin
                n_checks++; if ({LOCK_OWN, LOCK_TO} !== 3'b010) $display("FAIL timeout_held_%0d: got %b want 010", k, {LOCK_OWN, LOCK_TO}); else n_pass++;
            end else begin
                n_checks++; if ({LOCK_OWN, LOCK_TO} !== 3'b001) $display("FAIL timeout_fire: got %b want 001", {LOCK_OWN, LOCK_TO}); else n_pass++;
            end
        end
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (LOCK_TO === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL timeout_single_pulse: got %0d extra want 0", pulses); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int got, want;
        do_reset();
        D_BUSY = 1'b0; D_DO = 32'h0;
        set_m(0, 1, 32'hFFFF_FF00, 0, 32'h0);
        set_m(1, 1, 32'hFFFF_FF08, 0, 32'h0);
        for (int r = 0; r < 6; r++) begin
            apply();
            tick();
            got = (D_A === 32'hFFFF_FF00) ? 0 : (D_A === 32'hFFFF_FF08) ? 1 : -1;
`ifdef SH7604_DIVARB_RR_EN
            want = r % 2;
`else
            want = 0;
`endif
            n_checks++; if (got !== want) $display("FAIL b2b_round_%0d: got M%0d want M%0d", r, got, want); else n_pass++;
            if (want == 0) set_m(0, 0, 32'h0, 0, 32'h0);
            else set_m(1, 0, 32'h0, 0, 32'h0);
            apply();
            tick();
            set_m(0, 1, 32'hFFFF_FF00, 0, 32'h0);
            set_m(1, 1, 32'hFFFF_FF08, 0, 32'h0);
        end
        set_m(0, 0, 32'h0, 0, 32'h0);
        set_m(1, 0, 32'h0, 0, 32'h0);
        apply();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        D_BUSY = 1'b0; D_DO = 32'h0000_00AA;
        set_m(1, 1, 32'hFFFF_FF14, 1, 32'd9);
        apply();
        tick();
        tick();
        n_checks++; if ({LOCK_OWN, D_REQ} !== 3'b101) $display("FAIL mid_pre: got own/dreq %b want 101", {LOCK_OWN, D_REQ}); else n_pass++;
        RST_N = 1'b0;
        set_m(0, 1, 32'hFFFF_FE00, 0, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({D_REQ, M0_BUSY, M1_BUSY, LOCK_OWN, M0_DO} !== 37'd0)
            $display("FAIL mid_reset: got dreq=%b busy=%b%b own=%b do0=%h", D_REQ, M0_BUSY, M1_BUSY, LOCK_OWN, M0_DO);
        else n_pass++;
        RST_N = 1'b1;
        model_reset();
        apply();
        n_checks++;
        if ({M1_BUSY, D_REQ, M0_BUSY, M0_DO, LOCK_OWN} !== {1'b1, 1'b0, 1'b0, 32'd0, 2'b00})
            $display("FAIL mid_after: got b1=%b dreq=%b b0=%b do0=%h own=%b", M1_BUSY, D_REQ, M0_BUSY, M0_DO, LOCK_OWN);
        else n_pass++;
        set_m(1, 0, 32'h0, 0, 32'h0);
        apply();
        tick();
        n_checks++; if ({D_REQ, M0_BUSY, M0_DO} !== 34'd0) $display("FAIL mid_out_of_window: got dreq=%b b0=%b do0=%h", D_REQ, M0_BUSY, M0_DO); else n_pass++;
        set_m(0, 0, 32'h0, 0, 32'h0);
        apply();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [4:0] ofs;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'hFFFF_FE00 | 32'($urandom_range(0, 255));
        if (r == 1) return $urandom;
        case ($urandom_range(0, 5))
            0:       ofs = 5'h00;
            1:       ofs = 5'h04;
            2:       ofs = 5'h08;
            3:       ofs = 5'h14;
            4:       ofs = 5'h1C;
            default: ofs = 5'h10;
        endcase
        return 32'hFFFF_FF00 | {27'd0, ofs};
    endfunction

    task automatic test_random();
        logic [138:0] got, want;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 4) M0_REQ = ~M0_REQ;
            if ($urandom_range(0, 9) < 4) M1_REQ = ~M1_REQ;
            M0_A = rand_addr(); M1_A = rand_addr();
            M0_WE = 1'($urandom_range(0, 1)); M1_WE = 1'($urandom_range(0, 1));
            M0_DI = $urandom; M1_DI = $urandom;
            M0_BA = 4'($urandom_range(0, 15)); M1_BA = 4'($urandom_range(0, 15));
            D_BUSY = ($urandom_range(0, 3) == 0);
            D_DO = $urandom;
            apply();
            got  = {D_REQ, D_WE, D_BA, D_A, D_DI, M0_BUSY, M1_BUSY, M0_DO, M1_DO, LOCK_OWN, LOCK_TO};
            want = {e_dreq, e_dwe, e_dba, e_da, e_ddi, e_m0b, e_m1b, e_m0do, e_m1do, 2'(m_own), 1'(m_to)};
            n_checks++; if (got !== want) $display("FAIL random_%0d: got %h want %h", i, got, want); else n_pass++;
            tick();
        end
        set_m(0, 0, 32'h0, 0, 32'h0);
        set_m(1, 0, 32'h0, 0, 32'h0);
        apply();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; CE_R = 1'b0;
        M0_A = 0; M1_A = 0; M0_DI = 0; M1_DI = 0; M0_BA = 0; M1_BA = 0;
        M0_WE = 0; M1_WE = 0; M0_REQ = 0; M1_REQ = 0; D_DO = 0; D_BUSY = 0;
        model_reset();
        @(negedge CLK);
        test_reset();
        test_lock_basic();
        test_prio();
        test_lock_block();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
